// File: rtl/accum_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | accum_pkg : shared widths, drain FSM state type and chunk-limit helper.   |
// | Revision  : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package accum_pkg;

  localparam int ACC_WIDTH_DEF  = 8;
  localparam int DATA_WIDTH_DEF = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  // 2^dw-1, saturated to the all-ones value of an aw-bit accumulator.
  function automatic logic [31:0] max_chunk(input int dw, input int aw);
    int bits;
    bits = (dw < aw) ? dw : aw;
    if (bits >= 32) return '1;
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/accum_chunk_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | accum_chunk_sel : chunk = min(remaining_in, MAX_CHUNK), is_last when the  |
// |                   whole remainder fits in one chunk. Combinational only.  |
// | Revision        : 1.0 - initial release                                   |
// +----------------------------------------------------------------------------+
module accum_chunk_sel
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic [ACC_WIDTH-1:0]  remaining_in,
  output logic [DATA_WIDTH-1:0] chunk,
  output logic                  is_last
);

  generate
    if (DATA_WIDTH < ACC_WIDTH) begin : g_narrow
      localparam logic [ACC_WIDTH-1:0] C_MAX_CHUNK =
        ACC_WIDTH'(max_chunk(DATA_WIDTH, ACC_WIDTH));

      assign is_last = (remaining_in <= C_MAX_CHUNK);
      assign chunk   = is_last ? remaining_in[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b1}};
    end else begin : g_wide
      // A chunk can hold any total, so every remainder is a single final beat.
      assign is_last = 1'b1;
      assign chunk   = DATA_WIDTH'(remaining_in);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/accum_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | accum_drain : accepts one total and re-serialises it as a stream of       |
// |               bounded chunks with a last flag on the final beat.          |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module accum_drain
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [ACC_WIDTH-1:0]  load_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [ACC_WIDTH-1:0]  remaining,
  output logic                  busy
);

  drain_state_t          state_q, state_d;
  logic [ACC_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;

  logic [DATA_WIDTH-1:0] ld_chunk, nx_chunk;
  logic                  ld_last, nx_last;
  logic [ACC_WIDTH-1:0]  rem_after;
  logic                  xfer;

  // Chunk never exceeds remaining, so this subtraction cannot wrap.
  assign rem_after = remaining_q - ACC_WIDTH'(out_data_q);
  assign xfer      = out_valid_q && out_ready;

  accum_chunk_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_sel_load (
    .remaining_in (load_data),
    .chunk        (ld_chunk),
    .is_last      (ld_last)
  );

  accum_chunk_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_sel_next (
    .remaining_in (rem_after),
    .chunk        (nx_chunk),
    .is_last      (nx_last)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d     = DRAIN;
          remaining_d = load_data;
          out_valid_d = 1'b1;
          out_data_d  = ld_chunk;
          out_last_d  = ld_last;
        end
      end
      DRAIN: begin
        if (xfer) begin
          remaining_d = rem_after;
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
          end else begin
            out_data_d = nx_chunk;
            out_last_d = nx_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == DRAIN);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign remaining  = remaining_q;

endmodule
`default_nettype wire

// File: tb/tb_accum_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_accum_drain : scoreboard bench; expected beats come from a plain       |
// |                  arithmetic split of each accepted total.                 |
// | Revision       : 1.0 - initial release                                    |
// +----------------------------------------------------------------------------+
module tb_accum_drain;

  localparam int DW = 4;
  localparam int AW = 8;
  localparam int MAXC = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [AW-1:0] load_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [AW-1:0] remaining;
  logic          busy;

  accum_drain #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .remaining  (remaining),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int l;
    int r;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    xfer_cnt = 0;
  bit    ready_force = 1'b1;
  bit    ready_val   = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference split: full chunks of MAXC then the remainder; zero is one empty last beat.
  task automatic push_model(input int n);
    beat_t b;
    int    rem;
    if (n == 0) begin
      b.d = 0; b.l = 1; b.r = 0;
      exp_q.push_back(b);
    end else begin
      rem = n;
      while (rem > 0) begin
        b.d = (rem < MAXC) ? rem : MAXC;
        b.l = (rem <= MAXC) ? 1 : 0;
        b.r = rem;
        exp_q.push_back(b);
        rem -= b.d;
      end
    end
  endtask

  always @(posedge clk) begin
    #2;
    out_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard
  bit            exp_valid_next = 1'b0;
  bit            exp_idle_next  = 1'b0;
  bit            prev_stall     = 1'b0;
  int            prev_d, prev_l, prev_r;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_remaining", int'(remaining), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_load_ready", int'(load_ready), 1);
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_last", int'(out_last), 0);
      exp_q.delete();
      exp_valid_next = 1'b0;
      exp_idle_next  = 1'b0;
      prev_stall     = 1'b0;
    end else begin
      check("busy_vs_ready", int'(busy), int'(!load_ready));
      if (exp_valid_next) check("valid_after_load", int'(out_valid), 1);
      exp_valid_next = 1'b0;
      if (exp_idle_next) begin
        check("idle_load_ready", int'(load_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_out_data", int'(out_data), 0);
        check("idle_out_last", int'(out_last), 0);
      end
      exp_idle_next = 1'b0;
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), prev_d);
        check("stall_last", int'(out_last), prev_l);
        check("stall_remaining", int'(remaining), prev_r);
      end
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("beat_expected", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", int'(out_data), e.d);
          check("beat_last", int'(out_last), e.l);
          check("beat_remaining", int'(remaining), e.r);
          if (e.l != 0) exp_idle_next = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d = int'(out_data);
      prev_l = int'(out_last);
      prev_r = int'(remaining);
      if (load_valid && load_ready) begin
        check("load_while_pending", exp_q.size(), 0);
        push_model(int'(load_data));
        exp_valid_next = 1'b1;
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 600; i++) begin
      if (load_ready) return;
      @(posedge clk); #1;
    end
    check("wait_ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (load_ready && exp_q.size() == 0) return;
    end
    check("wait_idle_timeout", 0, 1);
  endtask

  task automatic do_load(input int n);
    wait_ready();
    load_valid = 1'b1;
    load_data  = AW'(n);
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_data  = AW'($urandom);
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    ready_force = 1'b1; ready_val = 1'b1;
    do_load(40);  wait_idle();
    do_load(0);   wait_idle();
    do_load(255); wait_idle();

    // Consumer stalls for three cycles on the first beat.
    ready_val = 1'b0;
    @(posedge clk); #1;
    do_load(20);
    for (int k = 0; k < 3; k++) begin
      check("hold_valid", int'(out_valid), 1);
      check("hold_data", int'(out_data), 15);
      check("hold_last", int'(out_last), 0);
      check("hold_remaining", int'(remaining), 20);
      if (k < 2) begin @(posedge clk); #1; end
    end
    ready_val = 1'b1;
    wait_idle();

    // Abort mid-stream.
    do_load(100);
    c0 = xfer_cnt;
    for (int i = 0; i < 50 && xfer_cnt < c0 + 2; i++) begin @(posedge clk); #1; end
    check("two_xfers_seen", xfer_cnt - c0, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_remaining", int'(remaining), 0);
    check("abort_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_load(7); wait_idle();

    // Request held during a drain must wait for IDLE.
    do_load(30);
    load_valid = 1'b1;
    load_data  = 8'd50;
    for (int i = 0; i < 100; i++) begin
      if (load_ready) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    wait_idle();

    // Randomised loads with a randomly stalling consumer.
    ready_force = 1'b0;
    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) do_load(int'($urandom_range(0, 16)));
      else do_load(int'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 0) begin
        load_valid = 1'b1;
        load_data  = AW'($urandom);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        if (busy) load_valid = 1'b0;
        else begin @(posedge clk); #1; load_valid = 1'b0; end
      end
      wait_idle();
    end

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
